pc_unit: RTL and testbench

- Parametrised program-counter unit; successor of the fetch-stage PC selector.
- Holds the PC register and chooses the next PC from sequential, first-instruction, interrupt, branch, call, return and return-from-interrupt sources.
- Adds an internal return-address stack (RAS), an exception PC (EPC) register, and interrupt-active tracking.
- Drives the instruction-memory address in the fetch stage.

---
 rtl/pc_pkg.sv | 21 ++
 rtl/pc_ras.sv | 68 ++++++
 rtl/pc_unit.sv | 114 +++++++++++
 tb/tb_pc_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: next-PC source encodings and default vectors shared by pc_unit and its bench.
package pc_pkg;

    localparam logic [2:0] SEL_NEXT   = 3'b000;
    localparam logic [2:0] SEL_FIRST  = 3'b001;
    localparam logic [2:0] SEL_INT    = 3'b010;
    localparam logic [2:0] SEL_BRANCH = 3'b011;
    localparam logic [2:0] SEL_CALL   = 3'b100;
    localparam logic [2:0] SEL_RET    = 3'b101;
    localparam logic [2:0] SEL_RETI   = 3'b110;
    localparam logic [2:0] SEL_HOLD   = 3'b111;

    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0020;
    localparam logic [31:0] DEFAULT_INT_VEC   = 32'h0000_0000;

    // Sources whose target is known in the same cycle and can be forwarded to fetch.
    function automatic logic is_redirect(input logic [2:0] sel);
        return (sel == SEL_BRANCH) || (sel == SEL_CALL);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; 1-cycle push/pop, top read combinationally at the pre-pop top.
// No backpressure: push when full overwrites the oldest entry, pop when empty only pulses o_underflow.
module pc_ras #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_push_dat,
    output logic [ADDR_W-1:0] o_top_dat,
    output logic              o_empty,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic [PTR_W-1:0]  w_top_ptr;
    logic              w_full;
    logic              w_empty;

    // The write pointer names the next free slot; when full it names the oldest entry.
    assign w_top_ptr = r_wr_ptr - PTR_W'(1);
    assign w_full    = (r_count == CNT_W'(RAS_DEPTH));
    assign w_empty   = (r_count == '0);

    assign o_top_dat   = r_mem[w_top_ptr];
    assign o_empty     = w_empty;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= i_push && w_full;
            r_underflow <= i_pop && w_empty;
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (!w_full) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else if (i_pop && !w_empty) begin
                r_wr_ptr <= w_top_ptr;
                r_count  <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch PC register with RAS, EPC and interrupt tracking; 1-cycle redirect, 0-cycle on branch/call with PC_BYPASS_EN.
// No backpressure: pc_enable=0 freezes PC, RAS, EPC and suppresses the RAS pulses.
module pc_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEFAULT_RESET_VEC),
    parameter logic [ADDR_W-1:0] INT_VEC   = ADDR_W'(DEFAULT_INT_VEC),
    parameter logic [ADDR_W-1:0] INC       = ADDR_W'(1),
    parameter int                RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_enable,
    input  logic [2:0]        sel,
    input  logic [ADDR_W-1:0] first_instruction_addr,
    input  logic [ADDR_W-1:0] target_addr,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] epc_out,
    output logic              int_active,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_epc;
    logic              r_int_active;

    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_epc_nxt;
    logic              w_int_nxt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_ras_top;
    logic              w_ras_empty;
    logic              w_push;
    logic              w_pop;

    assign w_pc_inc = r_pc + INC;

    always_comb begin
        w_pc_nxt  = r_pc;
        w_epc_nxt = r_epc;
        w_int_nxt = r_int_active;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        if (pc_enable) begin
            case (sel)
                SEL_NEXT:   w_pc_nxt = w_pc_inc;
                SEL_FIRST:  w_pc_nxt = first_instruction_addr;
                SEL_INT: begin
                    // Interrupts do not nest: a second request while active is a hold.
                    if (!r_int_active) begin
                        w_epc_nxt = r_pc;
                        w_pc_nxt  = INT_VEC;
                        w_int_nxt = 1'b1;
                    end
                end
                SEL_BRANCH: w_pc_nxt = target_addr;
                SEL_CALL: begin
                    w_push   = 1'b1;
                    w_pc_nxt = target_addr;
                end
                SEL_RET: begin
                    w_pop    = 1'b1;
                    w_pc_nxt = w_ras_empty ? RESET_VEC : w_ras_top;
                end
                SEL_RETI: begin
                    if (r_int_active) begin
                        w_pc_nxt  = r_epc;
                        w_int_nxt = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_VEC;
            r_epc        <= '0;
            r_int_active <= 1'b0;
        end else begin
            r_pc         <= w_pc_nxt;
            r_epc        <= w_epc_nxt;
            r_int_active <= w_int_nxt;
        end
    end

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_dat  (w_pc_inc),
        .o_top_dat   (w_ras_top),
        .o_empty     (w_ras_empty),
        .o_overflow  (ras_overflow),
        .o_underflow (ras_underflow)
    );

`ifdef PC_BYPASS_EN
    assign pc_out = (pc_enable && is_redirect(sel)) ? target_addr : r_pc;
`else
    assign pc_out = r_pc;
`endif

    assign epc_out    = r_epc;
    assign int_active = r_int_active;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors for pc_unit; expectations queued at issue and checked by a separate monitor.
module tb_pc_unit;
    import pc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_enable = 1'b0;
    logic [2:0]  sel = SEL_HOLD;
    logic [31:0] first_instruction_addr = '0;
    logic [31:0] target_addr = '0;
    logic [31:0] pc_out;
    logic [31:0] epc_out;
    logic        int_active;
    logic        ras_overflow;
    logic        ras_underflow;

`ifdef PC_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    pc_unit #(
        .ADDR_W    (32),
        .RESET_VEC (32'h20),
        .INT_VEC   (32'h0),
        .INC       (32'h1),
        .RAS_DEPTH (4)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .pc_enable              (pc_enable),
        .sel                    (sel),
        .first_instruction_addr (first_instruction_addr),
        .target_addr            (target_addr),
        .pc_out                 (pc_out),
        .epc_out                (epc_out),
        .int_active             (int_active),
        .ras_overflow           (ras_overflow),
        .ras_underflow          (ras_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       tag;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        ia;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t q_post[$];
    exp_t q_pre[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    function automatic exp_t mk(input int c, input string tag, input logic [31:0] pc,
                                input logic [31:0] epc, input logic ia, input logic ovf, input logic unf);
        exp_t e;
        e.cyc = c; e.tag = tag; e.pc = pc; e.epc = epc; e.ia = ia; e.ovf = ovf; e.unf = unf;
        return e;
    endfunction

    task automatic compare(input exp_t e);
        checks++;
        if (pc_out !== e.pc || epc_out !== e.epc || int_active !== e.ia ||
            ras_overflow !== e.ovf || ras_underflow !== e.unf) begin
            errors++;
            $display("FAIL %s: got pc=%h epc=%h ia=%b ovf=%b unf=%b, expected pc=%h epc=%h ia=%b ovf=%b unf=%b",
                     e.tag, pc_out, epc_out, int_active, ras_overflow, ras_underflow,
                     e.pc, e.epc, e.ia, e.ovf, e.unf);
        end
    endtask

    // Monitor: post-edge state is sampled 1 time unit after each rising edge,
    // same-cycle (combinational / async) views 2 units after each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (q_post.size() > 0 && q_post[0].cyc == cyc) begin
                e = q_post.pop_front();
                compare(e);
            end
            @(negedge clk);
            #2;
            while (q_pre.size() > 0 && q_pre[0].cyc == cyc) begin
                e = q_pre.pop_front();
                compare(e);
            end
        end
    end

    // One cycle of stimulus; expectation is the state seen after the next rising edge.
    task automatic step(input logic en, input logic [2:0] s, input logic [31:0] addr, input string tag,
                        input logic [31:0] e_pc, input logic [31:0] e_epc,
                        input logic e_ia, input logic e_ovf, input logic e_unf);
        @(negedge clk);
        pc_enable = en;
        sel       = s;
        if (s == SEL_FIRST) begin
            first_instruction_addr = addr;
            target_addr            = 32'hBAD0_0000;
        end else begin
            first_instruction_addr = 32'hF00D_0000;
            target_addr            = addr;
        end
        q_post.push_back(mk(cyc + 1, tag, e_pc, e_epc, e_ia, e_ovf, e_unf));
    endtask

    // Branch with an additional same-cycle check of the fetch address.
    task automatic branch_chk(input logic en, input logic [31:0] addr, input string tag,
                              input logic [31:0] e_pre, input logic [31:0] e_post, input logic [31:0] e_epc);
        @(negedge clk);
        pc_enable              = en;
        sel                    = SEL_BRANCH;
        target_addr            = addr;
        first_instruction_addr = 32'hF00D_0000;
        q_pre.push_back(mk(cyc, {tag, "_same"}, e_pre, e_epc, 1'b0, 1'b0, 1'b0));
        q_post.push_back(mk(cyc + 1, tag, e_post, e_epc, 1'b0, 1'b0, 1'b0));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        pc_enable = 1'b1;
        sel       = SEL_HOLD;
        q_pre.push_back(mk(cyc, "reset", 32'h20, 32'h0, 1'b0, 1'b0, 1'b0));

        step(1, SEL_NEXT, 32'h0, "next1", 32'h21, 32'h0, 0, 0, 0);
        step(1, SEL_NEXT, 32'h0, "next2", 32'h22, 32'h0, 0, 0, 0);
        step(1, SEL_NEXT, 32'h0, "next3", 32'h23, 32'h0, 0, 0, 0);

        step(1, SEL_FIRST, 32'h40,  "first40",   32'h40,  32'h0, 0, 0, 0);
        step(1, SEL_CALL,  32'h100, "call100",   32'h100, 32'h0, 0, 0, 0);
        step(1, SEL_NEXT,  32'h0,   "call_next", 32'h101, 32'h0, 0, 0, 0);
        step(1, SEL_RET,   32'h0,   "ret41",     32'h41,  32'h0, 0, 0, 0);

        branch_chk(1, 32'h80, "branch80", BYP ? 32'h80 : 32'h41, 32'h80, 32'h0);

        step(1, SEL_FIRST, 32'h55, "first55", 32'h55, 32'h0,  0, 0, 0);
        step(1, SEL_INT,   32'h0,  "int",     32'h0,  32'h55, 1, 0, 0);
        step(1, SEL_INT,   32'h0,  "int_nest",32'h0,  32'h55, 1, 0, 0);
        step(1, SEL_RETI,  32'h0,  "reti",    32'h55, 32'h55, 0, 0, 0);
        step(1, SEL_RETI,  32'h0,  "reti_idle",32'h55,32'h55, 0, 0, 0);

        step(1, SEL_CALL,  32'h10, "call10",  32'h10, 32'h55, 0, 0, 0);
        step(1, SEL_CALL,  32'h11, "call11",  32'h11, 32'h55, 0, 0, 0);
        step(1, SEL_CALL,  32'h12, "call12",  32'h12, 32'h55, 0, 0, 0);
        step(1, SEL_CALL,  32'h13, "call13",  32'h13, 32'h55, 0, 0, 0);
        step(1, SEL_CALL,  32'h14, "call14_ovf", 32'h14, 32'h55, 0, 1, 0);
        step(1, SEL_BRANCH,32'h90, "branch90",32'h90, 32'h55, 0, 0, 0);
        step(1, SEL_RET,   32'h0,  "ret14",   32'h14, 32'h55, 0, 0, 0);
        step(1, SEL_RET,   32'h0,  "ret13",   32'h13, 32'h55, 0, 0, 0);
        step(1, SEL_RET,   32'h0,  "ret12",   32'h12, 32'h55, 0, 0, 0);
        step(1, SEL_RET,   32'h0,  "ret11",   32'h11, 32'h55, 0, 0, 0);
        step(1, SEL_RET,   32'h0,  "ret_unf", 32'h20, 32'h55, 0, 0, 1);
        step(1, SEL_NEXT,  32'h0,  "unf_clr", 32'h21, 32'h55, 0, 0, 0);

        branch_chk(0, 32'h77, "en0_branch", 32'h21, 32'h21, 32'h55);
        q_post[q_post.size()-1].epc = 32'h55;
        step(0, SEL_CALL,  32'h33, "en0_call",  32'h21, 32'h55, 0, 0, 0);
        step(1, SEL_RET,   32'h0,  "ret_empty", 32'h20, 32'h55, 0, 0, 1);
        step(0, SEL_RET,   32'h0,  "en0_ret",   32'h20, 32'h55, 0, 0, 0);

        step(1, SEL_FIRST, 32'hFFFF_FFFF, "first_max", 32'hFFFF_FFFF, 32'h55, 0, 0, 0);
        step(1, SEL_NEXT,  32'h0,         "next_wrap", 32'h0,         32'h55, 0, 0, 0);
        step(1, SEL_FIRST, 32'hFFFF_FFFF, "first_max2",32'hFFFF_FFFF, 32'h55, 0, 0, 0);
        step(1, SEL_CALL,  32'h200,       "call_wrap", 32'h200,       32'h55, 0, 0, 0);
        step(1, SEL_RET,   32'h0,         "ret_wrap",  32'h0,         32'h55, 0, 0, 0);

        step(1, SEL_CALL,  32'h300, "call300", 32'h300, 32'h55,  0, 0, 0);
        step(1, SEL_INT,   32'h0,   "int2",    32'h0,   32'h300, 1, 0, 0);
        @(negedge clk);
        sel = SEL_HOLD;
        q_pre.push_back(mk(cyc, "async_rst", 32'h20, 32'h0, 1'b0, 1'b0, 1'b0));
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(1, SEL_FIRST, 32'h60, "first60",   32'h60, 32'h0, 0, 0, 0);
        step(1, SEL_RET,   32'h0,  "ret_after_rst", 32'h20, 32'h0, 0, 0, 1);
        step(1, SEL_HOLD,  32'h0,  "hold",      32'h20, 32'h0, 0, 0, 0);

        @(negedge clk);
        pc_enable = 1'b0;
        sel       = SEL_HOLD;
        for (int i = 0; i < 20 && (q_post.size() > 0 || q_pre.size() > 0); i++) begin
            @(negedge clk);
        end
        if (q_post.size() > 0 || q_pre.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations never checked, required 0", q_post.size() + q_pre.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
